// File: rtl/multi_edge_synchronizer.sv
// Multi-channel synchronizer: flop chain, optional debounce (SYNC_DEBOUNCE_EN), edge detect with sticky pending/overrun.
// Latency: STAGES+1 edges to out_sync_sig/event_pulse, or STAGES+DEBOUNCE_CYCLES with debounce.
// Backpressure: none; an event arriving while pending and not acked is dropped and flagged in overrun.
module multi_edge_synchronizer #(
    parameter int CHANNELS        = 4,
    parameter int STAGES          = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                outclk,
    input  logic                clr,
    input  logic [CHANNELS-1:0] async_sig,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] out_sync_sig,
    output logic [CHANNELS-1:0] event_pulse,
    output logic [CHANNELS-1:0] event_pending,
    output logic [CHANNELS-1:0] overrun
);

    if (STAGES < 2) begin : g_bad_stages
        $error("multi_edge_synchronizer: STAGES must be at least 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_edge_synchronizer: CHANNELS must be at least 1");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
        $error("multi_edge_synchronizer: EDGE_MODE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("multi_edge_synchronizer: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0] lvl_q, lvl_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] overrun_q, overrun_d;
    logic [CHANNELS-1:0] synced;
    logic [CHANNELS-1:0] edge_vec;

    always_comb begin
        sync_d[0] = async_sig;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign synced = sync_q[STAGES-1];

`ifdef SYNC_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (synced[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                lvl_d[i] = ~lvl_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge outclk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        lvl_d = synced;
    end
`endif

    always_comb begin
        edge_vec = '0;
        if (EDGE_MODE == 0) begin
            edge_vec = lvl_d & ~lvl_q;
        end else if (EDGE_MODE == 1) begin
            edge_vec = ~lvl_d & lvl_q;
        end else begin
            edge_vec = lvl_d ^ lvl_q;
        end
    end

    // A new event takes priority over a simultaneous acknowledge.
    always_comb begin
        pulse_d   = edge_vec;
        pending_d = edge_vec | (pending_q & ~ack);
        overrun_d = overrun_q | (edge_vec & pending_q & ~ack);
    end

    always_ff @(posedge outclk) begin
        if (clr) begin
            sync_q    <= '0;
            lvl_q     <= '0;
            pulse_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_sync_sig  = lvl_q;
    assign event_pulse   = pulse_q;
    assign event_pending = pending_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_multi_edge_synchronizer.sv
// Directed bench for multi_edge_synchronizer: three instances (rising, falling, both edges) on shared stimulus.
// Honours SYNC_DEBOUNCE_EN for expected latency and glitch-filter scenarios.
module tb_multi_edge_synchronizer;

`ifdef SYNC_DEBOUNCE_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2 + 1;
`endif

    logic       outclk = 1'b0;
    logic       clr;
    logic [3:0] a;
    logic [3:0] ack;
    logic [3:0] out0, pul0, pen0, ovr0;
    logic [3:0] out1, pul1, pen1, ovr1;
    logic [3:0] out2, pul2, pen2, ovr2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 outclk = ~outclk;

    multi_edge_synchronizer #(.CHANNELS(4), .STAGES(2), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4)) u_rise (
        .outclk(outclk), .clr(clr), .async_sig(a), .ack(ack),
        .out_sync_sig(out0), .event_pulse(pul0), .event_pending(pen0), .overrun(ovr0));

    multi_edge_synchronizer #(.CHANNELS(4), .STAGES(2), .EDGE_MODE(1), .DEBOUNCE_CYCLES(4)) u_fall (
        .outclk(outclk), .clr(clr), .async_sig(a), .ack(ack),
        .out_sync_sig(out1), .event_pulse(pul1), .event_pending(pen1), .overrun(ovr1));

    multi_edge_synchronizer #(.CHANNELS(4), .STAGES(2), .EDGE_MODE(2), .DEBOUNCE_CYCLES(4)) u_both (
        .outclk(outclk), .clr(clr), .async_sig(a), .ack(ack),
        .out_sync_sig(out2), .event_pulse(pul2), .event_pending(pen2), .overrun(ovr2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge outclk);
            #1;
        end
    endtask

    initial begin
        clr = 1'b1;
        a   = 4'b0000;
        ack = 4'b0000;
        tick(3);
        check("reset_out", 32'(out0), 32'h0);
        check("reset_pulse", 32'({pul0, pul1, pul2}), 32'h0);
        check("reset_pending", 32'({pen0, pen1, pen2}), 32'h0);
        check("reset_overrun", 32'({ovr0, ovr1, ovr2}), 32'h0);
        clr = 1'b0;
        tick(2);

        // Basic rise on channel 0
        a = 4'b0001;
        tick(LAT - 1);
        check("rise_early_out", 32'(out0), 32'h0);
        check("rise_early_pulse", 32'(pul0), 32'h0);
        tick(1);
        check("rise_out", 32'(out0), 32'h1);
        check("rise_pulse", 32'(pul0), 32'h1);
        check("rise_pending", 32'(pen0), 32'h1);
        check("rise_fall_mode_pulse", 32'(pul1), 32'h0);
        check("rise_both_mode_pulse", 32'(pul2), 32'h1);
        tick(1);
        check("rise_pulse_one_cycle", 32'(pul0), 32'h0);
        check("rise_pending_held", 32'(pen0), 32'h1);
        ack = 4'b0001;
        tick(1);
        ack = 4'b0000;
        check("ack_clears", 32'(pen0), 32'h0);
        ack = 4'b0010;
        tick(1);
        ack = 4'b0000;
        check("ack_idle_pending", 32'(pen0), 32'h0);
        check("ack_idle_overrun", 32'(ovr0), 32'h0);

        // Acknowledge coinciding with a new event on channel 2
        a[2] = 1'b1;
        tick(LAT);
        check("ch2_pulse", 32'(pul0), 32'h4);
        check("ch2_pending", 32'(pen0), 32'h4);
        a[2] = 1'b0;
        tick(LAT + 1);
        a[2] = 1'b1;
        tick(LAT - 1);
        ack = 4'b0100;
        tick(1);
        ack = 4'b0000;
        check("ackvs_pulse", 32'(pul0[2]), 32'h1);
        check("ackvs_pending", 32'(pen0[2]), 32'h1);
        check("ackvs_overrun", 32'(ovr0[2]), 32'h0);
        a[2] = 1'b0;
        tick(LAT + 1);
        a[2] = 1'b1;
        tick(LAT);
        check("overrun_set", 32'(ovr0), 32'h4);
        check("overrun_pending", 32'(pen0[2]), 32'h1);
        tick(3);
        check("overrun_sticky", 32'(ovr0), 32'h4);

        // Channel 3: rise, hold 5 cycles, fall
        a[3] = 1'b1;
        for (int t = 1; t <= LAT + 7; t++) begin
            tick(1);
            check($sformatf("edges_rise_t%0d", t), 32'(pul0[3]), 32'(t == LAT));
            check($sformatf("edges_fall_t%0d", t), 32'(pul1[3]), 32'(t == LAT + 5));
            check($sformatf("edges_both_t%0d", t), 32'(pul2[3]), 32'(t == LAT || t == LAT + 5));
            if (t == 5) a[3] = 1'b0;
        end
        check("fall_mode_pending", 32'(pen1[3]), 32'h1);

`ifdef SYNC_DEBOUNCE_EN
        // Short glitch on channel 1 is filtered, sustained level passes
        a[1] = 1'b1;
        tick(2);
        a[1] = 1'b0;
        for (int t = 3; t <= LAT + 5; t++) begin
            tick(1);
            check($sformatf("glitch_pulse_t%0d", t), 32'(pul2[1]), 32'h0);
            check($sformatf("glitch_out_t%0d", t), 32'(out0[1]), 32'h0);
        end
        a[1] = 1'b1;
        for (int t = 1; t <= LAT + 1; t++) begin
            tick(1);
            check($sformatf("deb_out_t%0d", t), 32'(out0[1]), 32'(t >= LAT));
            check($sformatf("deb_pulse_t%0d", t), 32'(pul0[1]), 32'(t == LAT));
        end
`else
        // One-cycle input pulse on channel 1 gives back-to-back edges
        a[1] = 1'b1;
        tick(1);
        a[1] = 1'b0;
        for (int t = 2; t <= LAT + 3; t++) begin
            tick(1);
            check($sformatf("b2b_both_t%0d", t), 32'(pul2[1]), 32'(t == LAT || t == LAT + 1));
            check($sformatf("b2b_rise_t%0d", t), 32'(pul0[1]), 32'(t == LAT));
        end
`endif

        // Reset part-way through the chain / debounce count
        clr = 1'b1;
        a   = 4'b0000;
        tick(2);
        clr = 1'b0;
        a   = 4'b0001;
        tick(LAT - 2);
        clr = 1'b1;
        tick(1);
        check("mid_clr_out", 32'(out0), 32'h0);
        check("mid_clr_pulse", 32'(pul0), 32'h0);
        check("mid_clr_pending", 32'(pen0), 32'h0);
        check("mid_clr_overrun", 32'(ovr0), 32'h0);
        clr = 1'b0;
        tick(LAT - 1);
        check("post_clr_early", 32'(pul0), 32'h0);
        tick(1);
        check("post_clr_pulse", 32'(pul0), 32'h1);
        check("post_clr_out", 32'(out0), 32'h1);

        // All channels together, selective acknowledge
        clr = 1'b1;
        a   = 4'b0000;
        tick(2);
        clr = 1'b0;
        a   = 4'b1111;
        tick(LAT);
        check("all_pulse", 32'(pul0), 32'hf);
        check("all_pending", 32'(pen0), 32'hf);
        check("all_out", 32'(out0), 32'hf);
        ack = 4'b0101;
        tick(1);
        ack = 4'b0000;
        check("sel_ack", 32'(pen0), 32'ha);
        tick(1);
        check("sel_ack_hold", 32'(pen0), 32'ha);
        check("all_no_overrun", 32'(ovr0), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
